bp_be_stride_pf_sched: RTL
==========================

Name: bp_be_stride_pf_sched

Overview:
- Sequences stride prefetches from Reference Prediction Table (RPT) stride hits into the D-cache prefetch port.
- Holds one active stream and one pending stream.
- Walks each stream for prefetch_degree_p cache lines, yields to demand loads, stops at page boundaries, and suppresses same-line repeats.
- Sits in the BE checker between the RPT and the D-cache request arbiter.

Parameters:
- vaddr_width_p, 39, virtual address width (from proc params)
- stride_width_p, 8, signed stride width delivered by the RPT
- prefetch_degree_p, 4, lines issued per stream (>=1)
- block_offset_width_p, 6, log2 of cache line bytes
- page_offset_width_p, 12, log2 of page bytes

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- rpt_v_i  in  1  RPT stride-hit candidate valid
- rpt_pc_i  in  vaddr_width_p  PC of the striding load
- rpt_eff_addr_i  in  vaddr_width_p  effective address of that load
- rpt_stride_i  in  stride_width_p  signed two's-complement stride
- flush_i  in  1  pipeline flush; kill all streams
- demand_v_i  in  1  demand load using the D-cache port this cycle
- pf_v_o  out  1  prefetch request valid
- pf_addr_o  out  vaddr_width_p  line-aligned prefetch address
- pf_ready_i  in  1  D-cache accepts prefetch
- busy_o  out  1  active stream present
- drop_o  out  1  one-cycle pulse when a candidate or stream is discarded

Behaviour:
- Reset: async, active-high.
  - state=e_idle; active/pending valid=0; all registers 0.
  - pf_v_o=0, busy_o=0, drop_o=0 while reset_i is high and in the first cycle after release.
- Active stream registers: pc, base, stride (sign-extended to vaddr_width_p), remaining (width clog2(prefetch_degree_p+1)), last_line.
- Pending slot holds {pc, eff_addr, stride}.
- States:
  - e_idle -> e_active on an accepted candidate.
  - e_active -> e_idle when remaining hits 0 or a page crossing occurs, with pending empty.
  - If pending is valid at that point, the pending entry loads into the active stream in the same edge and the state stays e_active.
- Candidate acceptance, in priority order:
  1. flush_i wins: candidate ignored; active and pending cleared next edge; state -> e_idle.
  2. Stride 0: rejected, drop_o=1.
  3. Active stream with equal pc: restart the stream. Load base=eff_addr, remaining=prefetch_degree_p, last_line=eff_addr line, new stride. This overrides any handshake in the same cycle.
  4. Different pc while active: written to pending. drop_o=1 if pending was already valid (overwritten).
  5. e_idle: load directly into active.
- Next address and line are combinational from registers:
  - next = base + sext(stride), modulo 2^vaddr_width_p.
  - line(x) = x with the low block_offset_width_p bits zeroed; pf_addr_o = line(next).
- Per-cycle action in e_active, no flush:
  - Page crossing (next[vaddr-1:page_offset] != base[vaddr-1:page_offset]): terminate the stream, drop_o=1, pf_v_o=0.
  - Same line (line(next)==last_line): skip. base<=next, remaining--, no request, independent of demand_v_i and pf_ready_i.
  - Otherwise: pf_v_o = ~demand_v_i.
    - On pf_v_o & pf_ready_i: base<=next, last_line<=line(next), remaining--.
- pf_v_o is a non-sticky hint: it may deassert without a handshake (demand, flush, restart). The consumer must not rely on request stability.
- Latency: first request is visible the cycle after candidate acceptance. Throughput is at most one prefetch per cycle.
- busy_o = (state==e_active).
- The scheduler is independent of RPT init; rpt_v_i is never asserted before RPT init completes.

Decomposition:
- Shared package bp_be_pkg:
  - state enum bp_be_pf_state_e {e_idle, e_active}
  - struct bp_be_pf_stream_s {pc, base, stride, remaining, last_line}
  - struct bp_be_pf_cand_s {pc, eff_addr, stride}
- One natural sub-module: bp_be_pf_addr_gen (combinational next/line/page-cross/same-line compute), instantiated once for the active stream.
- Registers use an async-reset flop (bsg_dff_async_reset style).

Test Plan:
- Basic walk:
  - Stimulus: candidate pc=0x100, eff=0x1000, stride=64, degree 4, ready=1.
  - Response: pf_addr 0x1040, 0x1080, 0x10C0, 0x1100 on cycles 1-4; busy_o falls cycle 5; drop_o never set.
- Same-line skip:
  - Stimulus: eff=0x2000, stride=16.
  - Response: 3 skip cycles with no pf_v_o, then pf_addr=0x2040 with remaining=0 (4 advances total), then idle.
- Page cross:
  - Stimulus: eff=0x3FC0, stride=64.
  - Response: no request, drop_o pulse cycle 1, busy_o=0 cycle 2.
- Negative stride with demand gating:
  - Stimulus: eff=0x5100, stride=-64 (0xC0), demand_v_i high cycles 1-2.
  - Response: pf_v_o=0 cycles 1-2; pf_addr 0x50C0, 0x5080, 0x5040, 0x5000 on cycles 3-6.
- Pending/overwrite/restart:
  - Stimulus: during stream A, send B then C, then A's pc again.
  - Response: drop_o on C; A restarts with remaining=4; after A ends, C becomes active.
- Flush and reset:
  - Stimulus: flush_i with simultaneous rpt_v_i mid-stream.
  - Response: next cycle pf_v_o=0, busy_o=0, candidate ignored.
  - Stimulus: async reset_i asserted mid-stream between clock edges.
  - Response: outputs 0 immediately.

Source files
------------

// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared types for the BE stride prefetch scheduler.
//   - bp_be_pf_state_e  : scheduler state (idle / active stream)
//   - bp_be_pf_stream_s : active stream registers
//   - bp_be_pf_cand_s   : RPT candidate as held in the pending slot
// The struct field widths follow the localparams below. The scheduler's own
// parameters default to them and must be kept equal when overridden.
package bp_be_pkg;

    localparam int unsigned bp_be_vaddr_width_gp        = 39;
    localparam int unsigned bp_be_stride_width_gp       = 8;
    localparam int unsigned bp_be_pf_degree_gp          = 4;
    localparam int unsigned bp_be_pf_remaining_width_gp = $clog2(bp_be_pf_degree_gp + 1);

    typedef enum logic [0:0] {
        e_idle,
        e_active
    } bp_be_pf_state_e;

    typedef struct packed {
        logic [bp_be_vaddr_width_gp-1:0]        pc;
        logic [bp_be_vaddr_width_gp-1:0]        base;
        logic [bp_be_vaddr_width_gp-1:0]        stride;     // sign-extended
        logic [bp_be_pf_remaining_width_gp-1:0] remaining;
        logic [bp_be_vaddr_width_gp-1:0]        last_line;
    } bp_be_pf_stream_s;

    typedef struct packed {
        logic [bp_be_vaddr_width_gp-1:0]  pc;
        logic [bp_be_vaddr_width_gp-1:0]  eff_addr;
        logic [bp_be_stride_width_gp-1:0] stride;
    } bp_be_pf_cand_s;

endpackage

// File: rtl/bp_be_pf_addr_gen.sv
// bp_be_pf_addr_gen: combinational next-address compute for one stream.
//   base_i       : current stream base address
//   stride_i     : sign-extended stride
//   last_line_i  : line of the last issued (or initial) address
//   next_o       : base + stride, modulo 2^vaddr_width_p
//   next_line_o  : next_o with the block offset cleared
//   page_cross_o : next_o lies in a different page than base_i
//   same_line_o  : next_line_o equals last_line_i
module bp_be_pf_addr_gen #(
    parameter int unsigned vaddr_width_p        = 39,
    parameter int unsigned block_offset_width_p = 6,
    parameter int unsigned page_offset_width_p  = 12
) (
    input  logic [vaddr_width_p-1:0] base_i,
    input  logic [vaddr_width_p-1:0] stride_i,
    input  logic [vaddr_width_p-1:0] last_line_i,
    output logic [vaddr_width_p-1:0] next_o,
    output logic [vaddr_width_p-1:0] next_line_o,
    output logic                     page_cross_o,
    output logic                     same_line_o
);

    assign next_o       = base_i + stride_i;
    assign next_line_o  = {next_o[vaddr_width_p-1:block_offset_width_p],
                           {block_offset_width_p{1'b0}}};
    assign page_cross_o = next_o[vaddr_width_p-1:page_offset_width_p]
                          != base_i[vaddr_width_p-1:page_offset_width_p];
    assign same_line_o  = (next_line_o == last_line_i);

endmodule

// File: rtl/bp_be_stride_pf_sched.sv
// bp_be_stride_pf_sched: sequences stride prefetches from RPT stride hits
// into the D-cache prefetch port. One active stream, one pending stream.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   rpt_v_i/pc/eff/stride : RPT stride-hit candidate
//   flush_i             : kill all streams, ignore candidate
//   demand_v_i          : demand load owns the D-cache port this cycle
//   pf_v_o, pf_addr_o   : line-aligned prefetch request (non-sticky hint)
//   pf_ready_i          : D-cache accepts the prefetch
//   busy_o              : active stream present
//   drop_o              : pulse when a candidate or stream is discarded
module bp_be_stride_pf_sched
    import bp_be_pkg::*;
#(
    parameter int unsigned vaddr_width_p        = bp_be_vaddr_width_gp,
    parameter int unsigned stride_width_p       = bp_be_stride_width_gp,
    parameter int unsigned prefetch_degree_p    = bp_be_pf_degree_gp,
    parameter int unsigned block_offset_width_p = 6,
    parameter int unsigned page_offset_width_p  = 12
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      rpt_v_i,
    input  logic [vaddr_width_p-1:0]  rpt_pc_i,
    input  logic [vaddr_width_p-1:0]  rpt_eff_addr_i,
    input  logic [stride_width_p-1:0] rpt_stride_i,
    input  logic                      flush_i,
    input  logic                      demand_v_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_i,
    output logic                      busy_o,
    output logic                      drop_o
);

    localparam int unsigned rem_width_lp = bp_be_pf_remaining_width_gp;

    bp_be_pf_state_e  state_q, state_d;
    bp_be_pf_stream_s active_q, active_d;
    bp_be_pf_cand_s   pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             init_done_q;

    logic [vaddr_width_p-1:0] next_addr, next_line;
    logic                     page_cross, same_line;

    bp_be_pf_cand_s cand;
    logic           is_active, cand_v, cand_zero, cand_ok, restart;
    logic           pf_v, advance, stream_end, drop;

    function automatic bp_be_pf_stream_s load_stream(input bp_be_pf_cand_s c);
        bp_be_pf_stream_s s;
        s.pc        = c.pc;
        s.base      = c.eff_addr;
        s.stride    = {{(vaddr_width_p-stride_width_p){c.stride[stride_width_p-1]}}, c.stride};
        s.remaining = rem_width_lp'(prefetch_degree_p);
        s.last_line = {c.eff_addr[vaddr_width_p-1:block_offset_width_p],
                       {block_offset_width_p{1'b0}}};
        return s;
    endfunction

    bp_be_pf_addr_gen #(
        .vaddr_width_p        (vaddr_width_p),
        .block_offset_width_p (block_offset_width_p),
        .page_offset_width_p  (page_offset_width_p)
    ) u_addr_gen (
        .base_i       (active_q.base),
        .stride_i     (active_q.stride),
        .last_line_i  (active_q.last_line),
        .next_o       (next_addr),
        .next_line_o  (next_line),
        .page_cross_o (page_cross),
        .same_line_o  (same_line)
    );

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        drop     = 1'b0;

        cand.pc       = rpt_pc_i;
        cand.eff_addr = rpt_eff_addr_i;
        cand.stride   = rpt_stride_i;

        is_active = (state_q == e_active);
        // Candidates are ignored until the first edge after reset release, which
        // also keeps drop_o quiet in that cycle.
        cand_v    = rpt_v_i & init_done_q & ~flush_i;
        cand_zero = (rpt_stride_i == '0);
        cand_ok   = cand_v & ~cand_zero;
        restart   = cand_ok & is_active & (rpt_pc_i == active_q.pc);

        // Restart and flush pull the request so a handshake never races a reload.
        pf_v       = is_active & ~page_cross & ~same_line & ~demand_v_i & ~flush_i & ~restart;
        advance    = is_active & ~page_cross & (same_line | (pf_v & pf_ready_i));
        stream_end = is_active & ~restart
                     & (page_cross | (advance & (active_q.remaining <= rem_width_lp'(1))));

        if (flush_i) begin
            state_d  = e_idle;
            active_d = '0;
            pend_d   = '0;
            pend_v_d = 1'b0;
        end else begin
            if (advance) begin
                active_d.base      = next_addr;
                active_d.remaining = active_q.remaining - 1'b1;
                if (!same_line) begin
                    active_d.last_line = next_line;
                end
            end

            if (is_active && page_cross && !restart) begin
                drop = 1'b1;
            end

            if (stream_end) begin
                if (pend_v_q) begin
                    active_d = load_stream(pend_q);
                    pend_v_d = 1'b0;
                end else begin
                    state_d = e_idle;
                end
            end

            if (cand_v && cand_zero) begin
                drop = 1'b1;
            end else if (restart) begin
                active_d = load_stream(cand);
                state_d  = e_active;
            end else if (cand_ok && is_active && !(stream_end && !pend_v_q)) begin
                // A pending entry consumed on this edge is not an overwrite.
                pend_d   = cand;
                pend_v_d = 1'b1;
                if (pend_v_q && !stream_end) begin
                    drop = 1'b1;
                end
            end else if (cand_ok) begin
                // Idle, or the active stream retires with nothing pending.
                active_d = load_stream(cand);
                state_d  = e_active;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            active_q    <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            init_done_q <= 1'b1;
        end
    end

    assign pf_v_o    = pf_v;
    assign pf_addr_o = next_line;
    assign busy_o    = is_active;
    assign drop_o    = drop;

endmodule
